// File: rtl/spad_types_pkg.sv
// Shared types for the scratchpad SRAM controller slice.
//   NUM_BANKS / ELEM_W / BANK_DEPTH fix the scratchpad geometry; ROW_W is the
//   per-bank row address width. xbar_desc_t is the descriptor every requester
//   presents: per-bank row slot, crossbar shift amount, per-bank valid mask.
//   scpad_data is one full scratchpad row, one ELEM_W word per bank.
package spad_types_pkg;

  localparam int unsigned NUM_BANKS  = 32;
  localparam int unsigned ELEM_W     = 16;
  localparam int unsigned BANK_DEPTH = 64;
  localparam int unsigned ROW_W      = $clog2(BANK_DEPTH);
  localparam int unsigned SHIFT_W    = $clog2(NUM_BANKS);

  typedef logic [NUM_BANKS-1:0][ROW_W-1:0]  slot_mask;
  typedef logic [SHIFT_W-1:0]               shift_mask;
  typedef logic [NUM_BANKS-1:0]             valid_mask;
  typedef logic [NUM_BANKS-1:0][ELEM_W-1:0] scpad_data;

  typedef struct packed {
    slot_mask  slot;
    shift_mask shift;
    valid_mask valid;
  } xbar_desc_t;

  typedef enum logic [1:0] {OWN_BE, OWN_VC, OWN_SA} owner_e;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

  // Zero every word whose bank is not marked valid.
  function automatic scpad_data mask_words(input scpad_data d, input valid_mask v);
    scpad_data r;
    r = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (v[b]) r[b] = d[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/spad_bank.sv
// One scratchpad bank: single-port DEPTH x WIDTH array.
//   clk   : clock
//   we    : write enable (writes wdata at addr on the rising edge)
//   addr  : shared read/write row address
//   wdata : write word
//   rdata : word read at addr, READ_LAT cycles after it was presented
// The read is always active; the first pipeline stage is the registered
// array read, further stages only delay it.
module spad_bank #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem       [DEPTH];
  logic [WIDTH-1:0] rd_pipe_d [READ_LAT];
  logic [WIDTH-1:0] rd_pipe_q [READ_LAT];

  always_comb begin
    rd_pipe_d[0] = mem[addr];
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rd_pipe_q <= rd_pipe_d;
  end

  assign rdata = rd_pipe_q[READ_LAT-1];

endmodule

// File: rtl/spad_sram_ctrl.sv
// Scratchpad SRAM responder: arbitrates backend write (BE) and VC/SA read
// requests, grants one at a time, performs a single banked write or read per
// grant and returns read data to the owning frontend.
//   clk, rst            : clock, synchronous active-high reset
//   sram_req_{be,vc,sa} : level requests, held until granted
//   {be,vc,sa}_xbar_desc: per-requester descriptor (slot/shift/valid)
//   xbar_out            : write row from the crossbar, stable while req_be=1
//   sram_reserved_*     : one-cycle grant pulses (priority BE > VC > SA)
//   xbar_in_{vc,sa}     : masked read row for the owner, zero otherwise
//   resp_valid          : [1]=VC, [0]=SA one-cycle response pulse
//   resp_ready          : high while the controller is idle
//   resp_rdata          : masked read row of the current response, else zero
module spad_sram_ctrl
  import spad_types_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sram_req_be,
  input  logic       sram_req_vc,
  input  logic       sram_req_sa,
  input  xbar_desc_t be_xbar_desc,
  input  xbar_desc_t vc_xbar_desc,
  input  xbar_desc_t sa_xbar_desc,
  input  scpad_data  xbar_out,
  output logic       sram_reserved_be,
  output logic       sram_reserved_vc,
  output logic       sram_reserved_sa,
  output scpad_data  xbar_in_vc,
  output scpad_data  xbar_in_sa,
  output logic [1:0] resp_valid,
  output logic       resp_ready,
  output scpad_data  resp_rdata
);

  localparam int unsigned    CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LAT - 1);

  state_e           state_q,   state_d;
  owner_e           owner_q,   owner_d;
  slot_mask         slot_q,    slot_d;
  valid_mask        valid_q,   valid_d;
  scpad_data        wdata_q,   wdata_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;

  scpad_data bank_rdata;
  scpad_data rd_masked;

  // The crossbar has already applied the shift; only slot/valid matter here.
  logic unused_shift;
  assign unused_shift = ^{be_xbar_desc.shift, vc_xbar_desc.shift, sa_xbar_desc.shift};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Descriptor / data latches and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_BE;
      slot_q    <= '0;
      valid_q   <= '0;
      wdata_q   <= '0;
      lat_cnt_q <= '0;
    end else begin
      owner_q   <= owner_d;
      slot_q    <= slot_d;
      valid_q   <= valid_d;
      wdata_q   <= wdata_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Next state, including the latch captured on the grant cycle
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    slot_d    = slot_q;
    valid_d   = valid_q;
    wdata_d   = wdata_q;
    lat_cnt_d = '0;
    unique case (state_q)
      IDLE: begin
        if (sram_req_be) begin
          state_d = WRITE;
          owner_d = OWN_BE;
          slot_d  = be_xbar_desc.slot;
          valid_d = be_xbar_desc.valid;
          wdata_d = xbar_out;
        end else if (sram_req_vc) begin
          state_d = READ;
          owner_d = OWN_VC;
          slot_d  = vc_xbar_desc.slot;
          valid_d = vc_xbar_desc.valid;
        end else if (sram_req_sa) begin
          state_d = READ;
          owner_d = OWN_SA;
          slot_d  = sa_xbar_desc.slot;
          valid_d = sa_xbar_desc.valid;
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        if (lat_cnt_q == LAT_LAST) state_d = RESP;
        else                       lat_cnt_d = lat_cnt_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; everything but resp_ready is forced idle while rst is high so a
  // grant can never be issued for a cycle whose latch is discarded.
  always_comb begin
    sram_reserved_be = 1'b0;
    sram_reserved_vc = 1'b0;
    sram_reserved_sa = 1'b0;
    resp_valid       = '0;
    xbar_in_vc       = '0;
    xbar_in_sa       = '0;
    resp_rdata       = '0;
    resp_ready       = rst || (state_q == IDLE);
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if      (sram_req_be) sram_reserved_be = 1'b1;
          else if (sram_req_vc) sram_reserved_vc = 1'b1;
          else if (sram_req_sa) sram_reserved_sa = 1'b1;
        end
        RESP: begin
          if (owner_q == OWN_VC) begin
            resp_valid[1] = 1'b1;
            xbar_in_vc    = rd_masked;
            resp_rdata    = rd_masked;
          end else if (owner_q == OWN_SA) begin
            resp_valid[0] = 1'b1;
            xbar_in_sa    = rd_masked;
            resp_rdata    = rd_masked;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_masked = mask_words(bank_rdata, valid_q);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    spad_bank #(
      .DEPTH    (BANK_DEPTH),
      .WIDTH    (ELEM_W),
      .READ_LAT (READ_LAT)
    ) u_bank (
      .clk   (clk),
      .we    (!rst && (state_q == WRITE) && valid_q[b]),
      .addr  (slot_q[b]),
      .wdata (wdata_q[b]),
      .rdata (bank_rdata[b])
    );
  end

endmodule
